// File: rtl/div_share_pkg.sv
// Shared types and constants for the divider-sharing controller.
// No logic of its own; the helper below is purely combinational.
// No flow control here.
package div_share_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int          DIV_CYCLES = 34;
    localparam logic [31:0] ERR_QUOT   = 32'hFFFF_FFFF;

    // Divisors the iterative divider must never see: zero, or negative in signed mode.
    function automatic logic div_illegal(input logic u, input logic [31:0] y);
        return (y == 32'd0) || (u && y[31]);
    endfunction

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, cyclically.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter #(
    parameter int  NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider among NREQ requesters with round-robin grant.
// Latency: 35 ce-cycles per normal op, 1 for a rejected divisor; result pulses once.
// Backpressure: requests are held by the requester and only sampled while idle.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_u,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_quot,
    output logic [31:0]          rsp_rem,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 div_run,
    output logic                 div_u,
    output logic [31:0]          div_x,
    output logic [31:0]          div_y,
    input  logic                 div_stall,
    input  logic [31:0]          div_quot,
    input  logic [31:0]          div_rem
);

    localparam int IW = $clog2(NREQ);

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr, win_idx, grant_idx, ptr_nxt;
    logic [NREQ-1:0] grant;
    logic          sel_u, sel_bad;
    logic [31:0]   sel_x, sel_y;
    logic          lat_op, cap_res;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_u = |(req_u & grant);
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_x = req_x[32*i +: 32];
                sel_y = req_y[32*i +: 32];
            end
        end
    end

    assign sel_bad = div_illegal(sel_u, sel_y);
    assign ptr_nxt = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);

    always_comb begin
        state_nxt = state;
        lat_op    = 1'b0;
        cap_res   = 1'b0;
        case (state)
            ST_FLUSH: state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (|grant) begin
                    lat_op    = 1'b1;
                    state_nxt = sel_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!div_stall) begin
                    cap_res   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_FLUSH;
        endcase
    end

    // Reset lands in FLUSH so the divider sees run low before any new grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FLUSH;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            win_idx  <= '0;
            div_u    <= 1'b0;
            div_x    <= '0;
            div_y    <= '0;
            rsp_quot <= '0;
            rsp_rem  <= '0;
            rsp_err  <= 1'b0;
        end else if (ce) begin
            if (lat_op) begin
                win_idx <= grant_idx;
                rr_ptr  <= ptr_nxt;
                div_u   <= sel_u;
                div_x   <= sel_x;
                div_y   <= sel_y;
                if (sel_bad) begin
                    rsp_quot <= ERR_QUOT;
                    rsp_rem  <= sel_x;
                    rsp_err  <= 1'b1;
                end
            end
            if (cap_res) begin
                rsp_quot <= div_quot;
                rsp_rem  <= div_rem;
                rsp_err  <= 1'b0;
            end
        end
    end

    // Decoded from state, so the pulse naturally stretches across ce-low cycles.
    always_comb begin
        rsp_valid = '0;
        if (state == ST_DONE) begin
            rsp_valid[win_idx] = 1'b1;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign div_run = (state == ST_RUN);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl with a behavioural iterative divider attached.
module tb_div_share_ctrl;

    localparam int NREQ = 2;

    typedef struct {
        int          idx;
        logic        u;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          runs;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic [NREQ-1:0]   req, req_u;
    logic [32*NREQ-1:0] req_x, req_y;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_quot, rsp_rem;
    logic              rsp_err, busy, div_run, div_u;
    logic [31:0]       div_x, div_y;
    logic              div_stall;
    logic [31:0]       div_quot, div_rem;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   s_cnt = 0;
    int   run_cnt = 0;
    bit   ce_tog = 1'b0;
    exp_t sb[$];
    int   rsp_log[$];
    vec_t vecs[10];
    logic [63:0] mres;

    div_share_ctrl #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .ce(ce), .req(req), .req_u(req_u), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
        .busy(busy), .div_run(div_run), .div_u(div_u), .div_x(div_x), .div_y(div_y),
        .div_stall(div_stall), .div_quot(div_quot), .div_rem(div_rem)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic u, input logic [31:0] x, input logic [31:0] y);
        int sx, sy, q, r;
        if (y == 32'd0 || (u && y[31])) return 64'd0;
        if (!u) return {x / y, x % y};
        sx = x;
        sy = y;
        q = sx / sy;
        r = sx % sy;
        if (r != 0 && ((r < 0) != (sy < 0))) begin
            q = q - 1;
            r = r + sy;
        end
        return {q[31:0], r[31:0]};
    endfunction

    // Divider model: S counts ce cycles with run high, result presented only at S=33.
    always @(posedge clk) begin
        if (ce) begin
            if (!div_run) s_cnt <= 0;
            else if (s_cnt != 33) s_cnt <= s_cnt + 1;
        end
    end
    always_comb mres = ref_div(div_u, div_x, div_y);
    assign div_stall = div_run && (s_cnt != 33);
    assign div_quot  = (s_cnt == 33) ? mres[63:32] : 32'hBAD0_BAD0;
    assign div_rem   = (s_cnt == 33) ? mres[31:0]  : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) run_cnt <= 0;
        else if (ce && rsp_valid != '0) run_cnt <= 0;
        else if (ce && div_run) run_cnt <= run_cnt + 1;
    end

    initial begin
        ce = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ce = ce_tog ? ~ce : 1'b1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: one pop per response, taken on the ce-high cycle that leaves DONE.
    always @(negedge clk) begin
        logic [NREQ-1:0] oh;
        exp_t e;
        if (!rst && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else if (!ce) begin
                oh = '0;
                oh[sb[0].idx] = 1'b1;
                check("rsp_hold", 64'(rsp_valid), 64'(oh));
            end else begin
                e = sb.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                check("rsp_valid", 64'(rsp_valid), 64'(oh));
                check("rsp_quot", 64'(rsp_quot), 64'(e.q));
                check("rsp_rem", 64'(rsp_rem), 64'(e.r));
                check("rsp_err", 64'(rsp_err), 64'(e.e));
                check("run_cycles", 64'(run_cnt), 64'(e.runs));
                rsp_log.push_back(cyc);
            end
        end
    end

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_op(input vec_t v, output int lat);
        bit got;
        wait_idle();
        req_u[v.idx]           = v.u;
        req_x[32*v.idx +: 32]  = v.x;
        req_y[32*v.idx +: 32]  = v.y;
        sb.push_back('{v.idx, v.q, v.r, v.e, v.e ? 0 : 34});
        req[v.idx] = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(posedge clk);
            if (ce) lat++;
            @(negedge clk);
            if (rsp_valid[v.idx] && ce) got = 1'b1;
        end
        req[v.idx] = 1'b0;
        if (!got) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lat, cnt, w;
        vecs[0] = '{0, 1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0};
        vecs[1] = '{1, 1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF1, 32'd5,        1'b0};
        vecs[2] = '{0, 1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1};
        vecs[3] = '{1, 1'b1, 32'd5,          32'h8000_0000, 32'hFFFF_FFFF, 32'd5,       1'b1};
        vecs[4] = '{1, 1'b0, 32'hFFFF_FFFF,  32'd2,        32'h7FFF_FFFF, 32'd1,        1'b0};
        vecs[5] = '{0, 1'b0, 32'hFFFF_FFFF,  32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 1'b0};
        vecs[6] = '{0, 1'b1, 32'h8000_0000,  32'd3,        32'hD555_5555, 32'd1,        1'b0};
        vecs[7] = '{1, 1'b1, 32'hFFFF_FFF9,  32'd7,        32'hFFFF_FFFF, 32'd0,        1'b0};
        vecs[8] = '{1, 1'b0, 32'd0,          32'd5,        32'd0,         32'd0,        1'b0};
        vecs[9] = '{0, 1'b1, 32'd0,          32'd0,        32'hFFFF_FFFF, 32'd0,        1'b1};

        rst = 1'b1;
        req = '0; req_u = '0; req_x = '0; req_y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_div_run", 64'(div_run), 64'd0);
        check("reset_quot", 64'(rsp_quot), 64'd0);
        check("reset_rem", 64'(rsp_rem), 64'd0);
        check("reset_err", 64'(rsp_err), 64'd0);
        check("reset_div_xyu", {div_x, div_y} | 64'(div_u), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("flush_one_cycle", 64'(busy), 64'd0);

        // Table-driven single-requester ops, including rejected divisors.
        foreach (vecs[i]) begin
            do_op(vecs[i], lat);
            check($sformatf("latency_v%0d", i), 64'(lat), vecs[i].e ? 64'd1 : 64'd35);
        end

        // ce toggling every cycle: same result after 35 ce-high cycles.
        ce_tog = 1'b1;
        do_op(vecs[0], lat);
        ce_tog = 1'b0;
        check("latency_ce_toggle", 64'(lat), 64'd35);

        // Both requesters held: grants alternate 0,1,0,1 every 36 cycles.
        do_reset();
        rsp_log.delete();
        req_u = 2'b10;
        req_x = {32'hFFFF_FF9C, 32'd100};
        req_y = {32'd7, 32'd7};
        for (int k = 0; k < 4; k++)
            sb.push_back('{k % 2, vecs[k % 2].q, vecs[k % 2].r, 1'b0, 34});
        req = 2'b11;
        cnt = 0;
        for (int t = 0; t < 400 && cnt < 4; t++) begin
            @(negedge clk);
            if (rsp_valid != '0 && ce) cnt++;
        end
        req = '0;
        check("rr_count", 64'(cnt), 64'd4);
        @(negedge clk);
        if (rsp_log.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("rr_period", 64'(rsp_log[i] - rsp_log[i-1]), 64'd36);
        end else begin
            check("rr_log_size", 64'(rsp_log.size()), 64'd4);
        end

        // Reset in the middle of RUN: no response, FLUSH for one cycle, reissue works.
        wait_idle();
        req_u[0] = 1'b0;
        req_x[31:0] = 32'd100;
        req_y[31:0] = 32'd7;
        req[0] = 1'b1;
        w = 0;
        while (!div_run && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("midop_run_start", 64'(div_run), 64'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("midop_rst_valid", 64'(rsp_valid), 64'd0);
        check("midop_rst_busy", 64'(busy), 64'd1);
        check("midop_rst_run", 64'(div_run), 64'd0);
        check("midop_rst_quot", 64'(rsp_quot), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midop_flush_len", 64'(busy), 64'd0);
        check("midop_no_rsp", 64'(rsp_valid), 64'd0);
        do_op(vecs[0], lat);
        check("latency_after_rst", 64'(lat), 64'd35);

        repeat (5) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
